// File: rtl/biquad_seq_pkg.sv
// biquad_seq_pkg: select and state encodings shared by the biquad sequencer and its datapath mux
package biquad_seq_pkg;
  localparam logic [2:0] SEL_S_CERO = 3'b000;
  localparam logic [2:0] SEL_S_A1   = 3'b001;
  localparam logic [2:0] SEL_S_A2   = 3'b010;
  localparam logic [2:0] SEL_S_B0   = 3'b011;
  localparam logic [2:0] SEL_S_B1   = 3'b100;
  localparam logic [2:0] SEL_S_B2   = 3'b101;
  localparam logic [1:0] SEL_C_CERO = 2'b00;
  localparam logic [1:0] SEL_C_FK1  = 2'b01;
  localparam logic [1:0] SEL_C_FK2  = 2'b10;
  localparam logic [1:0] SEL_C_FK   = 2'b11;
  localparam logic [2:0] SEL_Z_CERO  = 3'b000;
  localparam logic [2:0] SEL_Z_UK    = 3'b001;
  localparam logic [2:0] SEL_Z_YK    = 3'b010;
  localparam logic [2:0] SEL_Z_ACUM1 = 3'b011;
  localparam logic [2:0] SEL_Z_ACUM2 = 3'b100;
  localparam logic [2:0] SEL_Z_ACUM3 = 3'b101;
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_M1   = 3'd1;
  localparam logic [2:0] ST_M2   = 3'd2;
  localparam logic [2:0] ST_M3   = 3'd3;
  localparam logic [2:0] ST_M4   = 3'd4;
  localparam logic [2:0] ST_M5   = 3'd5;
  localparam logic [2:0] ST_UPD  = 3'd6;
  // ld bit order: {acum1, acum2, acum3, fk, yk}
  typedef struct packed {
    logic [2:0] s;
    logic [1:0] c;
    logic [2:0] z;
    logic [4:0] ld;
  } step_t;
endpackage

// File: rtl/biquad_seq_rom.sv
// biquad_seq_rom: combinational MAC step -> {controlS, controlC, controlZ, load vector} table
module biquad_seq_rom
  import biquad_seq_pkg::*;
(
  input  logic [2:0] step,
  output step_t      row
);
  // one fixed row per MAC step; idle, update and unused encodings select cero with no load
  always_comb begin
    case (step)
      ST_M1:   row = '{SEL_S_A2, SEL_C_FK2, SEL_Z_UK,    5'b10000};
      ST_M2:   row = '{SEL_S_A1, SEL_C_FK1, SEL_Z_ACUM1, 5'b00010};
      ST_M3:   row = '{SEL_S_B2, SEL_C_FK2, SEL_Z_CERO,  5'b01000};
      ST_M4:   row = '{SEL_S_B1, SEL_C_FK1, SEL_Z_ACUM2, 5'b00100};
      ST_M5:   row = '{SEL_S_B0, SEL_C_FK,  SEL_Z_ACUM3, 5'b00001};
      default: row = '{SEL_S_CERO, SEL_C_CERO, SEL_Z_CERO, 5'b00000};
    endcase
  end
endmodule

// File: rtl/biquad_seq.sv
// biquad_seq: biquad IIR MAC sequencer; optional overrun monitor under IIR_OVERRUN_EN
module biquad_seq
  import biquad_seq_pkg::*;
#(
  parameter int MUL_LAT = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic [2:0] controlS,
  output logic [1:0] controlC,
  output logic [2:0] controlZ,
  output logic       ld_acum1,
  output logic       ld_acum2,
  output logic       ld_acum3,
  output logic       ld_fk,
  output logic       ld_yk,
  output logic       shift_dly,
  output logic       busy,
  output logic       done
`ifdef IIR_OVERRUN_EN
  ,
  output logic       overrun,
  output logic [7:0] overrun_cnt
`endif
);
  localparam int WW = MUL_LAT > 0 ? $clog2(MUL_LAT + 1) : 1;
  localparam logic [WW-1:0] LAST = WW'(MUL_LAT);
  logic [2:0] state_q, state_d;
  logic [WW-1:0] wait_q, wait_d;
  logic last, in_mac, in_upd;
  step_t row;
  assign last   = wait_q == LAST;
  assign in_mac = state_q inside {[ST_M1:ST_M5]};
  assign in_upd = state_q == ST_UPD;
  // step through M1..M5 holding each for MUL_LAT+1 cycles; start only counts in IDLE/UPD
  always_comb begin
    state_d = in_mac ? (last ? state_q + 3'd1 : state_q)
                     : ((state_q == ST_IDLE || in_upd) && start ? ST_M1 : ST_IDLE);
    wait_d  = in_mac && !last ? wait_q + 1'b1 : '0;
  end
  // state and wait counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end
  biquad_seq_rom u_rom (
    .step(state_q),
    .row (row)
  );
  assign controlS = row.s;
  assign controlC = row.c;
  assign controlZ = row.z;
  assign {ld_acum1, ld_acum2, ld_acum3, ld_fk, ld_yk} = row.ld & {5{last}};
  assign shift_dly = in_upd;
  assign done      = in_upd;
  assign busy      = in_mac || in_upd;
`ifdef IIR_OVERRUN_EN
  logic overrun_q, overrun_d, hit;
  logic [7:0] overrun_cnt_q, overrun_cnt_d;
  assign hit = start && in_mac;
  // sticky flag and saturating count of samples dropped mid-schedule
  always_comb begin
    overrun_d     = overrun_q | hit;
    overrun_cnt_d = overrun_cnt_q + 8'(hit && overrun_cnt_q != 8'hff);
  end
  // overrun state, cleared only by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun_q     <= 1'b0;
      overrun_cnt_q <= '0;
    end else begin
      overrun_q     <= overrun_d;
      overrun_cnt_q <= overrun_cnt_d;
    end
  end
  assign overrun     = overrun_q;
  assign overrun_cnt = overrun_cnt_q;
`endif
endmodule

// File: tb/tb_biquad_seq.sv
// tb_biquad_seq: checks biquad_seq (MUL_LAT=0 and 2) against a queue-based schedule model
module tb_biquad_seq;
  // row layout: {S[2:0], C[1:0], Z[2:0], ld_acum1, ld_acum2, ld_acum3, ld_fk, ld_yk, shift_dly, busy, done}
  localparam logic [15:0] R_IDLE = 16'h0000;
  localparam logic [15:0] R_M1   = 16'b010_10_001_00000_010;
  localparam logic [15:0] R_M1L  = 16'b010_10_001_10000_010;
  localparam logic [15:0] R_M5L  = 16'b011_11_101_00001_010;
  localparam logic [15:0] R_UPD  = 16'b000_00_000_00000_111;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start0 = 1'b0;
  logic start2 = 1'b0;
  always #5 clk = ~clk;
  logic [2:0] s0, z0, s2, z2;
  logic [1:0] c0, c2;
  logic [4:0] l0, l2;
  logic sh0, bz0, dn0, sh2, bz2, dn2;
  logic ov0, ov2;
  logic [7:0] oc0, oc2;
  logic [15:0] vec [2];
  assign vec[0] = {s0, c0, z0, l0, sh0, bz0, dn0};
  assign vec[1] = {s2, c2, z2, l2, sh2, bz2, dn2};
`ifndef IIR_OVERRUN_EN
  assign {ov0, ov2, oc0, oc2} = '0;
`endif
  biquad_seq #(.MUL_LAT(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0),
    .controlS(s0), .controlC(c0), .controlZ(z0),
    .ld_acum1(l0[4]), .ld_acum2(l0[3]), .ld_acum3(l0[2]), .ld_fk(l0[1]), .ld_yk(l0[0]),
    .shift_dly(sh0), .busy(bz0), .done(dn0)
`ifdef IIR_OVERRUN_EN
    , .overrun(ov0), .overrun_cnt(oc0)
`endif
  );
  biquad_seq #(.MUL_LAT(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2),
    .controlS(s2), .controlC(c2), .controlZ(z2),
    .ld_acum1(l2[4]), .ld_acum2(l2[3]), .ld_acum3(l2[2]), .ld_fk(l2[1]), .ld_yk(l2[0]),
    .shift_dly(sh2), .busy(bz2), .done(dn2)
`ifdef IIR_OVERRUN_EN
    , .overrun(ov2), .overrun_cnt(oc2)
`endif
  );
  int checks = 0;
  int errors = 0;
  int lat [2] = '{0, 2};
  logic [15:0] mq [2][$];
  logic movf [2];
  logic [7:0] mcnt [2];
  // expected output row for MAC step k (1..5) or the update cycle (k=6)
  function automatic logic [15:0] row(int k, bit ld);
    logic [7:0] sel;
    logic [4:0] l;
    sel = 8'h00;
    l = 5'b00000;
    case (k)
      1: begin sel = 8'b010_10_001; l = 5'b10000; end
      2: begin sel = 8'b001_01_011; l = 5'b00010; end
      3: begin sel = 8'b101_10_000; l = 5'b01000; end
      4: begin sel = 8'b100_01_100; l = 5'b00100; end
      5: begin sel = 8'b011_11_101; l = 5'b00001; end
      default: ;
    endcase
    return k == 6 ? R_UPD : {sel, ld ? l : 5'b00000, 3'b010};
  endfunction
  function automatic logic [15:0] mexp(int i);
    return mq[i].size() != 0 ? mq[i][0] : R_IDLE;
  endfunction
  // model: each accepted sample enqueues its whole visible schedule; a new sample is
  // accepted only when nothing is pending or the pending row is the update cycle
  always @(posedge clk or negedge rst_n) begin
    bit fr, s;
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        mq[i].delete();
        movf[i] = 1'b0;
        mcnt[i] = 8'd0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        fr = mq[i].size() == 0 || mq[i][0][2];
        s = i == 0 ? start0 : start2;
        if (s && !fr) begin
          movf[i] = 1'b1;
          if (mcnt[i] != 8'd255) mcnt[i] = mcnt[i] + 8'd1;
        end
        if (mq[i].size() != 0) void'(mq[i].pop_front());
        if (s && fr) begin
          for (int k = 1; k <= 5; k++)
            for (int j = 0; j <= lat[i]; j++) mq[i].push_back(row(k, j == lat[i]));
          mq[i].push_back(row(6, 1'b0));
        end
      end
    end
  end
  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask
  // advance to the next falling edge and compare both DUTs against the model
  task automatic tick();
    @(negedge clk);
    chk("model_lat0", vec[0], mexp(0));
    chk("model_lat2", vec[1], mexp(1));
`ifdef IIR_OVERRUN_EN
    chk("ovr_lat0", {15'b0, ov0}, {15'b0, movf[0]});
    chk("ovc_lat0", {8'b0, oc0}, {8'b0, mcnt[0]});
    chk("ovr_lat2", {15'b0, ov2}, {15'b0, movf[1]});
    chk("ovc_lat2", {8'b0, oc2}, {8'b0, mcnt[1]});
`endif
  endtask
  initial begin
    start0 = 1'b1;
    start2 = 1'b1;
    repeat (2) tick();
    chk("rst_lat0", vec[0], R_IDLE);
    chk("rst_lat2", vec[1], R_IDLE);
    start0 = 1'b0;
    start2 = 1'b0;
    rst_n = 1'b1;
    repeat (3) tick();
    chk("idle_hold", vec[0], R_IDLE);
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    chk("l0_c1", vec[0], R_M1L);
    repeat (4) tick();
    chk("l0_c5", vec[0], R_M5L);
    tick();
    chk("l0_c6", vec[0], R_UPD);
    tick();
    chk("l0_c7", vec[0], R_IDLE);
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    chk("l2_c1", vec[1], R_M1);
    repeat (2) tick();
    chk("l2_c3", vec[1], R_M1L);
    repeat (13) tick();
    chk("l2_c16", vec[1], R_UPD);
    tick();
    chk("l2_c17", vec[1], R_IDLE);
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    tick();
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    tick();
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    chk("ign_c5", vec[0], R_M5L);
    tick();
    chk("ign_c6", vec[0], R_UPD);
    tick();
    chk("ign_c7", vec[0], R_IDLE);
`ifdef IIR_OVERRUN_EN
    chk("ovr_flag", {15'b0, ov0}, 16'd1);
    chk("ovr_cnt2", {8'b0, oc0}, 16'd2);
`endif
    start0 = 1'b1;
    repeat (6) tick();
    chk("b2b_c6", vec[0], R_UPD);
    tick();
    chk("b2b_c7", vec[0], R_M1L);
    repeat (5) tick();
    chk("b2b_c12", vec[0], R_UPD);
    repeat (8) tick();
    start0 = 1'b0;
    repeat (8) tick();
    chk("b2b_drain", vec[0], R_IDLE);
`ifdef IIR_OVERRUN_EN
    start0 = 1'b1;
    repeat (360) tick();
    start0 = 1'b0;
    repeat (8) tick();
    chk("ovr_sat", {8'b0, oc0}, 16'd255);
`endif
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    repeat (2) tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst", vec[0], R_IDLE);
    tick();
    rst_n = 1'b1;
`ifdef IIR_OVERRUN_EN
    chk("ovr_clr", {8'b0, oc0}, 16'd0);
`endif
    tick();
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    chk("post_rst_m1", vec[0], R_M1L);
    repeat (8) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
